// File: rtl/line_follower_pkg.sv
// Shared types and constants for the line-following robot controller.
// The timebase counts 10 ns ticks; one PWM period spans PERIOD_LAST+1 counts.
package line_follower_pkg;

    localparam int TIMEBASE_WIDTH = 21;
    localparam logic [TIMEBASE_WIDTH-1:0] PERIOD_LAST = 21'd1_999_999;

    typedef enum logic [2:0] {
        RESET,
        FORWARD,
        GENTLE_LEFT,
        SHARP_LEFT,
        GENTLE_RIGHT,
        SHARP_RIGHT
    } robot_state;

    // Sensor bits are {left, mid, right}; ambiguous patterns fall back to FORWARD.
    function automatic robot_state decode_sensor(input logic [2:0] sensor);
        robot_state result;
        case (sensor)
            3'b110:  result = GENTLE_LEFT;
            3'b100:  result = SHARP_LEFT;
            3'b011:  result = GENTLE_RIGHT;
            3'b001:  result = SHARP_RIGHT;
            default: result = FORWARD;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sensor_sync.sv
// Two-stage synchroniser for the asynchronous line sensors.
// Both stages clear asynchronously so reset never lets a stale reading through.
module sensor_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/robot_controller.sv
// Line-follower steering FSM: samples the synchronised sensors once per PWM
// period and drives Moore motor commands so no PWM pulse is ever truncated.
module robot_controller
    import line_follower_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2:0]                sensor,
    input  logic [TIMEBASE_WIDTH-1:0] count_in,
    output logic                      count_reset,
    output logic                      motor_l_reset,
    output logic                      motor_r_reset,
    output logic                      motor_l_direction,
    output logic                      motor_r_direction
);

    logic [2:0] sensor_s;
    robot_state state;
    robot_state next_state;
    logic       period_end;

    sensor_sync #(.WIDTH(3)) u_sensor_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sensor),
        .q     (sensor_s)
    );

    // Greater-or-equal so a timebase overshoot still closes the period.
    assign period_end = (count_in >= PERIOD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        count_reset = 1'b0;
        case (state)
            RESET: begin
                count_reset = 1'b1;
                next_state  = decode_sensor(sensor_s);
            end
            default: begin
                if (period_end) begin
                    count_reset = 1'b1;
                    next_state  = decode_sensor(sensor_s);
                end
            end
        endcase
    end

    // Motor commands depend on the state register alone, keeping them glitch-free.
    always_comb begin
        motor_l_reset     = 1'b1;
        motor_l_direction = 1'b0;
        motor_r_reset     = 1'b1;
        motor_r_direction = 1'b0;
        case (state)
            FORWARD: begin
                motor_l_reset     = 1'b0;
                motor_l_direction = 1'b0;
                motor_r_reset     = 1'b0;
                motor_r_direction = 1'b1;
            end
            GENTLE_LEFT: begin
                motor_l_reset     = 1'b1;
                motor_l_direction = 1'b0;
                motor_r_reset     = 1'b0;
                motor_r_direction = 1'b1;
            end
            SHARP_LEFT: begin
                motor_l_reset     = 1'b0;
                motor_l_direction = 1'b1;
                motor_r_reset     = 1'b0;
                motor_r_direction = 1'b1;
            end
            GENTLE_RIGHT: begin
                motor_l_reset     = 1'b0;
                motor_l_direction = 1'b0;
                motor_r_reset     = 1'b1;
                motor_r_direction = 1'b0;
            end
            SHARP_RIGHT: begin
                motor_l_reset     = 1'b0;
                motor_l_direction = 1'b0;
                motor_r_reset     = 1'b0;
                motor_r_direction = 1'b0;
            end
            default: begin
                motor_l_reset     = 1'b1;
                motor_l_direction = 1'b0;
                motor_r_reset     = 1'b1;
                motor_r_direction = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_robot_controller.sv
// Self-checking bench for robot_controller: directed vector table, hand-written
// reset corner cases, then randomized traffic against a behavioural model.
module tb_robot_controller;

    localparam logic [20:0] LAST = 21'd1_999_999;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sensor;
    logic [20:0] count_in;
    logic        count_reset;
    logic        motor_l_reset;
    logic        motor_r_reset;
    logic        motor_l_direction;
    logic        motor_r_direction;

    robot_controller dut (
        .clk               (clk),
        .reset             (reset),
        .sensor            (sensor),
        .count_in          (count_in),
        .count_reset       (count_reset),
        .motor_l_reset     (motor_l_reset),
        .motor_r_reset     (motor_r_reset),
        .motor_l_direction (motor_l_direction),
        .motor_r_direction (motor_r_direction)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  sen;
        logic [20:0] cnt;
        logic [3:0]  mot;
        logic        cr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: expected motor tuple, whether in reset, and raw sensor
    // samples taken at each clock edge (front = oldest still pending).
    logic [3:0] m_mot;
    bit         m_in_reset;
    logic [2:0] m_hist[$];

    // Motor tuple (l_reset, l_dir, r_reset, r_dir) the robot should drive for a reading.
    function automatic logic [3:0] drive_for(input logic [2:0] s);
        case (s)
            3'b110:  return 4'b1001;
            3'b100:  return 4'b0101;
            3'b011:  return 4'b0010;
            3'b001:  return 4'b0000;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic add(input logic r, input logic [2:0] s, input logic [20:0] c,
                       input logic [3:0] mot, input logic cr);
        vec_t v;
        v.rst = r; v.sen = s; v.cnt = c; v.mot = mot; v.cr = cr;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] mot, input logic cr);
        logic [4:0] act;
        act = {motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction, count_reset};
        checks++;
        if (act === {mot, cr}) passes++;
        else $display("[TB] FAIL %s: got mot=%b cr=%b, expected mot=%b cr=%b",
                      name, act[4:1], act[0], mot, cr);
    endtask

    // Drive inputs between edges; an asserted reset takes effect at once.
    task automatic applyStimulus(input logic r, input logic [2:0] s, input logic [20:0] c);
        reset    = r;
        sensor   = s;
        count_in = c;
        if (r) begin
            m_in_reset = 1'b1;
            m_mot      = 4'b1010;
            m_hist     = {3'b000, 3'b000};
        end
        #1;
    endtask

    // Advance one clock edge and update the model; a reading is acted on two edges after it is sampled.
    task automatic clockEdge();
        logic [2:0] seen;
        @(posedge clk);
        if (!reset) begin
            seen = m_hist.pop_front();
            if (m_in_reset || count_in >= LAST) begin
                m_mot      = drive_for(seen);
                m_in_reset = 1'b0;
            end
            m_hist.push_back(sensor);
        end
        #1;
    endtask

    initial begin
        m_in_reset = 1'b1;
        m_mot      = 4'b1010;
        m_hist     = {3'b000, 3'b000};

        // Release from reset, then a plain FORWARD period.
        add(1, 3'b010, 21'd0,         4'b1010, 1);
        add(1, 3'b010, 21'd0,         4'b1010, 1);
        add(0, 3'b010, 21'd0,         4'b1010, 1);
        add(0, 3'b010, 21'd1,         4'b0001, 0);
        add(0, 3'b010, 21'd1_999_998, 4'b0001, 0);
        add(0, 3'b010, 21'd1_999_999, 4'b0001, 1);
        add(0, 3'b010, 21'd0,         4'b0001, 0);
        // Mid-period change to 110 waits for period end.
        add(0, 3'b110, 21'd500_000,   4'b0001, 0);
        add(0, 3'b110, 21'd500_001,   4'b0001, 0);
        add(0, 3'b110, 21'd500_002,   4'b0001, 0);
        add(0, 3'b110, 21'd1_999_999, 4'b0001, 1);
        add(0, 3'b110, 21'd0,         4'b1001, 0);
        // Change one cycle before end is deferred a full period.
        add(0, 3'b011, 21'd1_999_998, 4'b1001, 0);
        add(0, 3'b011, 21'd1_999_999, 4'b1001, 1);
        add(0, 3'b011, 21'd0,         4'b1001, 0);
        add(0, 3'b011, 21'd1_999_999, 4'b1001, 1);
        add(0, 3'b011, 21'd0,         4'b0010, 0);
        // Back to FORWARD, then a one-cycle glitch that must be ignored.
        add(0, 3'b010, 21'd1,         4'b0010, 0);
        add(0, 3'b010, 21'd2,         4'b0010, 0);
        add(0, 3'b010, 21'd1_999_999, 4'b0010, 1);
        add(0, 3'b010, 21'd0,         4'b0001, 0);
        add(0, 3'b001, 21'd1_000_000, 4'b0001, 0);
        add(0, 3'b010, 21'd1_000_001, 4'b0001, 0);
        add(0, 3'b010, 21'd1_000_002, 4'b0001, 0);
        add(0, 3'b010, 21'd1_999_999, 4'b0001, 1);
        add(0, 3'b010, 21'd0,         4'b0001, 0);
        // Overshooting count still ends the period.
        add(0, 3'b100, 21'd5,         4'b0001, 0);
        add(0, 3'b100, 21'd6,         4'b0001, 0);
        add(0, 3'b100, 21'd2_000_050, 4'b0001, 1);
        add(0, 3'b100, 21'd0,         4'b0101, 0);
        // Into SHARP_RIGHT.
        add(0, 3'b001, 21'd1,         4'b0101, 0);
        add(0, 3'b001, 21'd2,         4'b0101, 0);
        add(0, 3'b001, 21'd1_999_999, 4'b0101, 1);
        add(0, 3'b001, 21'd0,         4'b0000, 0);
        add(0, 3'b001, 21'd1_234_566, 4'b0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].sen, vecs[i].cnt);
            checkOutput($sformatf("vec%0d", i), vecs[i].mot, vecs[i].cr);
            clockEdge();
        end

        // Reset mid-period in SHARP_RIGHT acts without a clock edge.
        applyStimulus(0, 3'b001, 21'd1_234_567);
        checkOutput("sharp_right_before_reset", 4'b0000, 0);
        applyStimulus(1, 3'b001, 21'd1_234_567);
        checkOutput("async_reset_immediate", 4'b1010, 1);
        clockEdge();
        applyStimulus(0, 3'b010, 21'd1_234_568);
        checkOutput("reset_release_state", 4'b1010, 1);
        clockEdge();
        applyStimulus(0, 3'b010, 21'd5);
        checkOutput("fresh_period_forward", 4'b0001, 0);
        clockEdge();
        // Reset coinciding with period end wins.
        applyStimulus(1, 3'b110, 21'd1_999_999);
        checkOutput("reset_at_period_end", 4'b1010, 1);
        clockEdge();
        applyStimulus(1, 3'b110, 21'd1_999_999);
        checkOutput("reset_held_over_edge", 4'b1010, 1);
        clockEdge();
        applyStimulus(0, 3'b110, 21'd7);
        checkOutput("release_after_coincide", 4'b1010, 1);
        clockEdge();
        applyStimulus(0, 3'b110, 21'd8);
        checkOutput("decoded_zero_sync", 4'b0001, 0);
        clockEdge();

        // Randomized traffic against the model.
        begin
            logic [2:0]  s = 3'b010;
            logic [20:0] c;
            logic        r;
            int          hold = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) s = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0)
                    c = LAST - 21'd2 + 21'($urandom_range(0, 60));
                else
                    c = 21'($urandom_range(0, 1_999_990));
                if (hold == 0 && $urandom_range(0, 149) == 0) hold = $urandom_range(1, 3);
                r = (hold > 0);
                if (hold > 0) hold--;
                applyStimulus(r, s, c);
                checkOutput($sformatf("rand%0d", i), m_mot, m_in_reset ? 1'b1 : (c >= LAST));
                clockEdge();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
